mem_access_unit: RTL and testbench

Load/store front end that sits directly upstream of the word-only data memory in the MIPS single-cycle datapath. It accepts byte, halfword and word load/store requests from the core and performs alignment checking and address range checking. It executes sub-word stores as a read-modify-write sequence, and sign/zero-extends sub-word loads. Its memory-side outputs drive the data memory's memRd, memWr, memAccessAdr and memWriteData ports, and it consumes memReadData.

---
 rtl/mem_access_unit_if.sv | 32 +++
 rtl/mem_access_unit.sv | 166 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and data-memory bundle for mem_access_unit
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        memRd;
  logic        memWr;
  logic [31:0] memAccessAdr;
  logic [31:0] memWriteData;
  logic [31:0] memReadData;

  // The unit side: takes requests, answers them and drives the data memory.
  modport slave (
    input  req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, memReadData,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output memRd, memWr, memAccessAdr, memWriteData
  );

  // The environment side: the core issuing requests plus the word memory.
  modport master (
    output req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, memReadData,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  memRd, memWr, memAccessAdr, memWriteData
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/half/word load-store front end with RMW for a word-only data memory
module mem_access_unit #(
  parameter int ADDR_BITS = 10
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [31:0] ADDR_MASK = ~((32'd1 << ADDR_BITS) - 32'd1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state;
  state_t      next_state;

  logic        lat_wr;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [1:0]  lat_lo;
  logic [15:0] lat_wdata;

  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        req_ready;
  logic        accept;
  logic        req_err;

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] lo, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] word, input logic [15:0] data,
                                        input logic [1:0] size, input logic [1:0] lo);
    logic [31:0] r;
    r = word;
    if (size == SZ_BYTE) begin
      case (lo)
        2'd0:    r[7:0]   = data[7:0];
        2'd1:    r[15:8]  = data[7:0];
        2'd2:    r[23:16] = data[7:0];
        default: r[31:24] = data[7:0];
      endcase
    end else if (lo[1]) begin
      r[31:16] = data;
    end else begin
      r[15:0] = data;
    end
    return r;
  endfunction

  // Held low while reset is asserted so nothing is accepted during reset.
  assign req_ready = (state == IDLE) && rst;
  assign accept    = bus.req_valid && req_ready;

  assign req_err = (bus.req_size == 2'b11)
                 || ((bus.req_size == SZ_HALF) && bus.req_addr[0])
                 || ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00))
                 || (|(bus.req_addr & ADDR_MASK));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)
            next_state = RESP;
          else if (bus.req_wr && (bus.req_size == SZ_WORD))
            next_state = WRITE;
          else
            next_state = READ;
        end
      end
      READ:    next_state = lat_wr ? WRITE : RESP;
      WRITE:   next_state = RESP;
      default: next_state = IDLE;
    endcase
  end

  // Strobes and response flags are registered images of the state being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lat_wr     <= 1'b0;
      lat_size   <= 2'b00;
      lat_signed <= 1'b0;
      lat_lo     <= 2'b00;
      lat_wdata  <= 16'h0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_adr    <= 32'h0;
      mem_wdata  <= 32'h0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      mem_rd     <= (next_state == READ);
      mem_wr     <= (next_state == WRITE);
      resp_valid <= (next_state == RESP);

      if (accept) begin
        lat_wr     <= bus.req_wr;
        lat_size   <= bus.req_size;
        lat_signed <= bus.req_signed;
        lat_lo     <= bus.req_addr[1:0];
        lat_wdata  <= bus.req_wdata[15:0];
        if (!req_err) begin
          mem_adr <= {bus.req_addr[31:2], 2'b00};
          if (bus.req_wr && (bus.req_size == SZ_WORD))
            mem_wdata <= bus.req_wdata;
        end
      end

      if ((state == READ) && lat_wr)
        mem_wdata <= merge(bus.memReadData, lat_wdata, lat_size, lat_lo);

      if (next_state == RESP) begin
        resp_err   <= (state == IDLE) && req_err;
        resp_rdata <= ((state == READ) && !lat_wr)
                      ? extract(bus.memReadData, lat_size, lat_lo, lat_signed) : 32'h0;
      end
    end
  end

  assign bus.req_ready    = req_ready;
  assign bus.resp_valid   = resp_valid;
  assign bus.resp_rdata   = resp_rdata;
  assign bus.resp_err     = resp_err;
  assign bus.memRd        = mem_rd;
  assign bus.memWr        = mem_wr;
  assign bus.memAccessAdr = mem_adr;
  assign bus.memWriteData = mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed scoreboard bench for mem_access_unit with a word memory model
module tb_mem_access_unit;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  int   rd_cnt;
  int   wr_cnt;
  int   resp_cnt;

  mem_access_unit_if bus();

  mem_access_unit #(.ADDR_BITS(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];

  logic [31:0] mem [0:255];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (bus.memWr === 1'b1) mem[bus.memAccessAdr[9:2]] <= bus.memWriteData;

  assign bus.memReadData = (bus.memRd === 1'b1) ? mem[bus.memAccessAdr[9:2]] : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.memRd === 1'b1) rd_cnt++;
    if (bus.memWr === 1'b1) wr_cnt++;
    if ((bus.memRd === 1'b1) || (bus.memWr === 1'b1))
      chk("rd_wr_exclusive", {31'h0, bus.memRd & bus.memWr}, 32'h0);
    if (q.size() > 0)
      chk("ready_while_busy", {31'h0, bus.req_ready}, 32'h0);
    if (bus.resp_valid === 1'b1) begin
      resp_cnt++;
      if (q.size() == 0) begin
        chk("unexpected_resp", {31'h0, bus.resp_valid}, 32'h0);
      end else begin
        e = q.pop_front();
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("resp_err", {31'h0, bus.resp_err}, {31'h0, e.err});
        chk("resp_latency", cyc - e.acc + 1, e.lat);
      end
    end
  end

  task automatic send(input logic wr, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                      output int acc);
    int   n;
    exp_t e;
    n = 0;
    bus.req_wr     = wr;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("accept_timeout", {31'h0, bus.req_ready}, 32'h1);
      acc = cyc;
    end else begin
      @(posedge clk);
      #1;
      acc     = cyc;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.lat   = lat;
      e.acc   = cyc;
      q.push_back(e);
    end
  endtask

  task automatic op(input logic wr, input logic [1:0] size, input logic sgn,
                    input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [31:0] exp_rdata, input logic exp_err, input int lat);
    int acc;
    send(wr, size, sgn, addr, wdata, exp_rdata, exp_err, lat, acc);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    int a1, a2, a3;
    int rsnap, wsnap, vsnap;
    checks = 0; errors = 0; rd_cnt = 0; wr_cnt = 0; resp_cnt = 0;
    rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h0);
    chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_resp_err", {31'h0, bus.resp_err}, 32'h0);
    chk("rst_memRd", {31'h0, bus.memRd}, 32'h0);
    chk("rst_memWr", {31'h0, bus.memWr}, 32'h0);
    chk("rst_memAccessAdr", bus.memAccessAdr, 32'h0);
    chk("rst_memWriteData", bus.memWriteData, 32'h0);
    rst = 1'b1;
    #1 chk("ready_after_rst", {31'h0, bus.req_ready}, 32'h1);

    // Word store then word load.
    op(1'b1, 2'b10, 1'b0, 32'h04, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    @(negedge clk);
    chk("wst_memWr_c1", {31'h0, bus.memWr}, 32'h1);
    chk("wst_adr_c1", bus.memAccessAdr, 32'h04);
    chk("wst_wdata_c1", bus.memWriteData, 32'hDEADBEEF);
    drain();
    op(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    drain();

    // Sub-word read-modify-write.
    op(1'b1, 2'b10, 1'b0, 32'h08, 32'h11223344, 32'h0, 1'b0, 2);
    drain();
    op(1'b1, 2'b00, 1'b0, 32'h09, 32'hFFFFFFAA, 32'h0, 1'b0, 3);
    @(negedge clk);
    chk("rmw_memRd_c1", {31'h0, bus.memRd}, 32'h1);
    chk("rmw_adr_c1", bus.memAccessAdr, 32'h08);
    @(negedge clk);
    chk("rmw_memWr_c2", {31'h0, bus.memWr}, 32'h1);
    chk("rmw_wdata_c2", bus.memWriteData, 32'h1122AA44);
    drain();
    op(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'h1122AA44, 1'b0, 2);
    drain();
    op(1'b1, 2'b01, 1'b1, 32'h0A, 32'h1234BEEF, 32'h0, 1'b0, 3);
    drain();
    op(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'hBEEFAA44, 1'b0, 2);
    drain();

    // Load extension.
    op(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, 32'h0, 1'b0, 2);
    drain();
    op(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 32'hFFFFFFFF, 1'b0, 2); drain();
    op(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 32'h000000FF, 1'b0, 2); drain();
    op(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFF80FF, 1'b0, 2); drain();
    op(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h00007F01, 1'b0, 2); drain();
    op(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h0000007F, 1'b0, 2); drain();
    op(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 2); drain();

    // Errors: no strobes, response in cycle 1.
    rsnap = rd_cnt; wsnap = wr_cnt;
    op(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1, 1); drain();
    chk("err_wload_no_rd", rd_cnt, rsnap);
    op(1'b1, 2'b01, 1'b0, 32'h03, 32'h5555, 32'h0, 1'b1, 1); drain();
    chk("err_hstore_no_wr", wr_cnt, wsnap);
    op(1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 32'h0, 1'b1, 1); drain();
    op(1'b0, 2'b00, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 1); drain();
    op(1'b1, 2'b10, 1'b0, 32'h8000_0000, 32'h1, 32'h0, 1'b1, 1); drain();
    chk("err_no_rd", rd_cnt, rsnap);
    chk("err_no_wr", wr_cnt, wsnap);

    // Reset during the READ cycle of a byte store.
    wsnap = wr_cnt; vsnap = resp_cnt;
    op(1'b1, 2'b00, 1'b0, 32'h08, 32'h77, 32'h0, 1'b0, 3);
    rst = 1'b0;
    @(posedge clk);
    #1 q.delete();
    @(negedge clk);
    chk("midrst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    chk("midrst_memRd", {31'h0, bus.memRd}, 32'h0);
    chk("midrst_memWr", {31'h0, bus.memWr}, 32'h0);
    chk("midrst_ready_low", {31'h0, bus.req_ready}, 32'h0);
    chk("midrst_memAccessAdr", bus.memAccessAdr, 32'h0);
    chk("midrst_memWriteData", bus.memWriteData, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready_high", {31'h0, bus.req_ready}, 32'h1);
    repeat (3) @(negedge clk);
    chk("midrst_no_wr", wr_cnt, wsnap);
    chk("midrst_no_resp", resp_cnt, vsnap);
    op(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'hBEEFAA44, 1'b0, 2);
    drain();

    // Back-to-back with req_valid held high.
    send(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'hDEADBEEF, 1'b0, 2, a1);
    send(1'b1, 2'b00, 1'b0, 32'h04, 32'h55, 32'h0, 1'b0, 3, a2);
    send(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'hDEADBE55, 1'b0, 2, a3);
    bus.req_valid = 1'b0;
    drain();
    chk("b2b_gap_load", a2 - a1, 3);
    chk("b2b_gap_substore", a3 - a2, 4);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
